// File: rtl/memory_arbiter_pkg.sv
// Shared types and helpers for the unified-memory arbiter.
//  arb_state_t : transaction FSM states
//  master_t    : which core port owns the current transaction
//  addr_fault  : alignment / range check on a full 32-bit byte address
package memory_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_t;

    typedef enum logic {
        IFETCH = 1'b0,
        DATA   = 1'b1
    } master_t;

    localparam int unsigned WORD_BYTES = 4;

    // A word access faults when it is misaligned or any of its bytes lies past
    // the end of memory. The compare is on the whole 32-bit address, so a high
    // address cannot wrap into the legal range.
    function automatic logic addr_fault(input logic [31:0] addr, input int unsigned mem_bytes);
        return (addr[1:0] != 2'b00) || (addr > 32'(mem_bytes - WORD_BYTES));
    endfunction

endpackage

// File: rtl/memory_arbiter_if.sv
// Bus bundle between the core (fetch + data ports), the arbiter and the memory.
//  slave  : arbiter view - takes requests and mem_rdata, drives completions and
//           the memory address/data/write-enable
//  master : environment view (core and memory), the mirror image
interface memory_arbiter_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_ready;
    logic [31:0] if_rdata;
    logic        if_fault;

    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic        dm_ready;
    logic [31:0] dm_rdata;
    logic        dm_fault;

    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic [31:0] mem_rdata;

    modport slave (
        input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
        output if_ready, if_rdata, if_fault, dm_ready, dm_rdata, dm_fault,
               mem_addr, mem_wdata, mem_we
    );

    modport master (
        output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
        input  if_ready, if_rdata, if_fault, dm_ready, dm_rdata, dm_fault,
               mem_addr, mem_wdata, mem_we
    );
endinterface

// File: rtl/memory_arbiter_rr_arbiter2.sv
// Two-way round-robin grant decision, purely combinational.
//  if_req, dm_req : current requests
//  last_grant     : port that won the previous grant (register kept by parent)
//  grant_valid    : at least one request present
//  grant          : winning port
module rr_arbiter2
    import memory_arbiter_pkg::*;
(
    input  logic    if_req,
    input  logic    dm_req,
    input  master_t last_grant,
    output logic    grant_valid,
    output master_t grant
);

    // Grant decision: contention goes to the port that did not win last time.
    always_comb begin
        grant_valid = 1'b0;
        grant       = IFETCH;
        if (if_req && dm_req) begin
            grant_valid = 1'b1;
            grant       = (last_grant == IFETCH) ? DATA : IFETCH;
        end else if (if_req) begin
            grant_valid = 1'b1;
            grant       = IFETCH;
        end else if (dm_req) begin
            grant_valid = 1'b1;
            grant       = DATA;
        end else begin
            grant_valid = 1'b0;
            grant       = IFETCH;
        end
    end

endmodule

// File: rtl/memory_arbiter.sv
// Arbiter sharing one big-endian single-port word memory between the MIPS
// fetch port and data port. One word per transaction, IDLE -> ACCESS -> RESP,
// WAIT_STATES extra ACCESS cycles, misaligned/out-of-range accesses fault
// straight to RESP without touching memory.
//  clk, reset : clock, synchronous active-high reset
//  bus        : core request/completion signals and memory address/data/we
//  busy       : high whenever the FSM is not in IDLE
module memory_arbiter
    import memory_arbiter_pkg::*;
#(
    parameter int unsigned MEM_BYTES   = 1024,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic              clk,
    input  logic              reset,
    memory_arbiter_if.slave   bus,
    output logic              busy
);

    localparam int unsigned CNT_W = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;

    arb_state_t        state_r;
    master_t           master_r;
    master_t           last_grant_r;
    logic              we_r;
    logic [CNT_W-1:0]  cnt_r;
    // The memory address/data registers double as the latched request: they
    // hold the granted values for the whole ACCESS phase and are 0 otherwise.
    logic [31:0]       mem_addr_r;
    logic [31:0]       mem_wdata_r;
    logic              if_ready_r;
    logic              if_fault_r;
    logic [31:0]       if_rdata_r;
    logic              dm_ready_r;
    logic              dm_fault_r;
    logic [31:0]       dm_rdata_r;
    logic              busy_r;

    logic              grant_valid_s;
    master_t           grant_s;
    logic [31:0]       req_addr_s;
    logic [31:0]       req_wdata_s;
    logic              req_we_s;
    logic              req_fault_s;
    logic              mem_we_s;
    logic [31:0]       resp_rdata_s;

    rr_arbiter2 u_rr (
        .if_req      (bus.if_req),
        .dm_req      (bus.dm_req),
        .last_grant  (last_grant_r),
        .grant_valid (grant_valid_s),
        .grant       (grant_s)
    );

    // Request fields of whichever port the round-robin picked this cycle.
    always_comb begin
        req_addr_s  = 32'h0000_0000;
        req_wdata_s = 32'h0000_0000;
        req_we_s    = 1'b0;
        if (grant_s == DATA) begin
            req_addr_s  = bus.dm_addr;
            req_wdata_s = bus.dm_wdata;
            req_we_s    = bus.dm_we;
        end else begin
            req_addr_s  = bus.if_addr;
            req_wdata_s = 32'h0000_0000;
            req_we_s    = 1'b0;
        end
        req_fault_s = addr_fault(req_addr_s, MEM_BYTES);
    end

    // Write strobe only in the last ACCESS cycle; memory commits it on negedge,
    // so a reset arriving in that cycle still lets the write land.
    always_comb begin
        mem_we_s     = 1'b0;
        resp_rdata_s = 32'h0000_0000;
        if ((state_r == ACCESS) && (cnt_r == {CNT_W{1'b0}})) begin
            mem_we_s = we_r;
        end else begin
            mem_we_s = 1'b0;
        end
        if (we_r) begin
            resp_rdata_s = 32'h0000_0000;
        end else begin
            resp_rdata_s = bus.mem_rdata;
        end
    end

    // Transaction FSM with all completion/memory outputs registered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= IDLE;
            master_r     <= IFETCH;
            last_grant_r <= DATA;
            we_r         <= 1'b0;
            cnt_r        <= {CNT_W{1'b0}};
            mem_addr_r   <= 32'h0000_0000;
            mem_wdata_r  <= 32'h0000_0000;
            if_ready_r   <= 1'b0;
            if_fault_r   <= 1'b0;
            if_rdata_r   <= 32'h0000_0000;
            dm_ready_r   <= 1'b0;
            dm_fault_r   <= 1'b0;
            dm_rdata_r   <= 32'h0000_0000;
            busy_r       <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (grant_valid_s) begin
                        master_r     <= grant_s;
                        last_grant_r <= grant_s;
                        we_r         <= req_we_s;
                        busy_r       <= 1'b1;
                        if (req_fault_s) begin
                            // Faulting access completes next cycle, memory untouched.
                            state_r    <= RESP;
                            if_ready_r <= (grant_s == IFETCH);
                            if_fault_r <= (grant_s == IFETCH);
                            if_rdata_r <= 32'h0000_0000;
                            dm_ready_r <= (grant_s == DATA);
                            dm_fault_r <= (grant_s == DATA);
                            dm_rdata_r <= 32'h0000_0000;
                        end else begin
                            state_r     <= ACCESS;
                            cnt_r       <= CNT_W'(WAIT_STATES);
                            mem_addr_r  <= req_addr_s;
                            mem_wdata_r <= req_wdata_s;
                        end
                    end else begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                    end
                end
                ACCESS: begin
                    if (cnt_r != {CNT_W{1'b0}}) begin
                        cnt_r <= cnt_r - CNT_W'(1);
                    end else begin
                        state_r     <= RESP;
                        mem_addr_r  <= 32'h0000_0000;
                        mem_wdata_r <= 32'h0000_0000;
                        if_ready_r  <= (master_r == IFETCH);
                        if_fault_r  <= 1'b0;
                        if_rdata_r  <= (master_r == IFETCH) ? resp_rdata_s : 32'h0000_0000;
                        dm_ready_r  <= (master_r == DATA);
                        dm_fault_r  <= 1'b0;
                        dm_rdata_r  <= (master_r == DATA) ? resp_rdata_s : 32'h0000_0000;
                    end
                end
                RESP: begin
                    state_r    <= IDLE;
                    busy_r     <= 1'b0;
                    if_ready_r <= 1'b0;
                    if_fault_r <= 1'b0;
                    if_rdata_r <= 32'h0000_0000;
                    dm_ready_r <= 1'b0;
                    dm_fault_r <= 1'b0;
                    dm_rdata_r <= 32'h0000_0000;
                end
                default: begin
                    state_r     <= IDLE;
                    busy_r      <= 1'b0;
                    mem_addr_r  <= 32'h0000_0000;
                    mem_wdata_r <= 32'h0000_0000;
                    if_ready_r  <= 1'b0;
                    dm_ready_r  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.mem_addr  = mem_addr_r;
    assign bus.mem_wdata = mem_wdata_r;
    assign bus.mem_we    = mem_we_s;
    assign bus.if_ready  = if_ready_r;
    assign bus.if_fault  = if_fault_r;
    assign bus.if_rdata  = if_rdata_r;
    assign bus.dm_ready  = dm_ready_r;
    assign bus.dm_fault  = dm_fault_r;
    assign bus.dm_rdata  = dm_rdata_r;
    assign busy          = busy_r;

endmodule

// File: tb/tb_memory_arbiter.sv
// Bench for memory_arbiter: dut0 with no wait states, dut1 with three. Each DUT
// has a byte-wide big-endian memory that commits writes on negedge; a word-level
// reference image per memory predicts read data.
module tb_memory_arbiter;

    logic clk = 1'b0;
    logic rst0;
    logic rst1;
    logic busy0;
    logic busy1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    memory_arbiter_if bus0();
    memory_arbiter_if bus1();

    memory_arbiter #(.MEM_BYTES(1024), .WAIT_STATES(0)) dut0 (
        .clk(clk), .reset(rst0), .bus(bus0), .busy(busy0));
    memory_arbiter #(.MEM_BYTES(1024), .WAIT_STATES(3)) dut1 (
        .clk(clk), .reset(rst1), .bus(bus1), .busy(busy1));

    logic [7:0]  mem0 [0:1023];
    logic [7:0]  mem1 [0:1023];
    logic [31:0] ref0 [0:255];
    logic [31:0] ref1 [0:255];
    logic [9:0]  ma0;
    logic [9:0]  ma1;
    logic        pl_we = 1'b0;
    logic [9:0]  pl_addr = 10'd0;
    logic [31:0] pl_data = 32'd0;
    int          we_pulses0 = 0;

    assign ma0 = {bus0.mem_addr[9:2], 2'b00};
    assign ma1 = {bus1.mem_addr[9:2], 2'b00};
    assign bus0.mem_rdata = {mem0[ma0], mem0[ma0 + 10'd1], mem0[ma0 + 10'd2], mem0[ma0 + 10'd3]};
    assign bus1.mem_rdata = {mem1[ma1], mem1[ma1 + 10'd1], mem1[ma1 + 10'd2], mem1[ma1 + 10'd3]};

    always @(negedge clk) begin
        if (bus0.mem_we) begin
            mem0[ma0]         <= bus0.mem_wdata[31:24];
            mem0[ma0 + 10'd1] <= bus0.mem_wdata[23:16];
            mem0[ma0 + 10'd2] <= bus0.mem_wdata[15:8];
            mem0[ma0 + 10'd3] <= bus0.mem_wdata[7:0];
            we_pulses0        <= we_pulses0 + 1;
        end else if (pl_we) begin
            mem0[pl_addr]         <= pl_data[31:24];
            mem0[pl_addr + 10'd1] <= pl_data[23:16];
            mem0[pl_addr + 10'd2] <= pl_data[15:8];
            mem0[pl_addr + 10'd3] <= pl_data[7:0];
        end
    end

    always @(negedge clk) begin
        if (bus1.mem_we) begin
            mem1[ma1]         <= bus1.mem_wdata[31:24];
            mem1[ma1 + 10'd1] <= bus1.mem_wdata[23:16];
            mem1[ma1 + 10'd2] <= bus1.mem_wdata[15:8];
            mem1[ma1 + 10'd3] <= bus1.mem_wdata[7:0];
        end else if (pl_we) begin
            mem1[pl_addr]         <= pl_data[31:24];
            mem1[pl_addr + 10'd1] <= pl_data[23:16];
            mem1[pl_addr + 10'd2] <= pl_data[15:8];
            mem1[pl_addr + 10'd3] <= pl_data[7:0];
        end
    end

    function automatic bit addr_bad(input logic [31:0] a);
        return (a[1:0] != 2'b00) || (a > 32'd1020);
    endfunction

    function automatic logic [31:0] rand_addr();
        int r;
        logic [31:0] v;
        r = $urandom_range(0, 9);
        v = 32'($urandom_range(0, 15)) << 2;
        if (r == 0) v[1:0] = 2'($urandom_range(1, 3));
        else if (r == 1) v = 32'h0000_0400 + (32'($urandom_range(0, 3)) << 2);
        else if (r == 2) v = 32'hFFFF_FFFC;
        else if (r == 3) v = 32'h0000_03FC;
        return v;
    endfunction

    // Writes one word into both memories and both reference images.
    task automatic preload(input logic [9:0] a, input logic [31:0] d);
        pl_addr = a;
        pl_data = d;
        pl_we   = 1'b1;
        @(negedge clk);
        #1;
        pl_we = 1'b0;
        ref0[a[9:2]] = d;
        ref1[a[9:2]] = d;
    endtask

    // One single-port transaction on dut0; lat = edges from drive to ready (0 = timeout).
    task automatic op0(input bit dm, input bit we, input logic [31:0] a, input logic [31:0] wd,
                       output logic [31:0] rd, output logic flt, output int lat);
        @(posedge clk);
        #1;
        if (dm) begin
            bus0.dm_req = 1'b1; bus0.dm_we = we; bus0.dm_addr = a; bus0.dm_wdata = wd;
        end else begin
            bus0.if_req = 1'b1; bus0.if_addr = a;
        end
        lat = 0; rd = 32'd0; flt = 1'b0;
        for (int k = 1; k <= 40 && lat == 0; k++) begin
            @(posedge clk);
            #1;
            if (dm ? bus0.dm_ready : bus0.if_ready) begin
                lat = k;
                rd  = dm ? bus0.dm_rdata : bus0.if_rdata;
                flt = dm ? bus0.dm_fault : bus0.if_fault;
            end
        end
        bus0.if_req = 1'b0;
        bus0.dm_req = 1'b0;
    endtask

    task automatic test_reset();
        checks++; if (busy0 !== 1'b0 || busy1 !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b%b exp=00", busy0, busy1); end
        checks++; if ({bus0.if_ready, bus0.dm_ready, bus1.if_ready, bus1.dm_ready} !== 4'b0000) begin errors++; $display("FAIL reset_ready got=%b%b%b%b exp=0000", bus0.if_ready, bus0.dm_ready, bus1.if_ready, bus1.dm_ready); end
        checks++; if (bus0.mem_we !== 1'b0 || bus0.mem_addr !== 32'd0 || bus0.mem_wdata !== 32'd0) begin errors++; $display("FAIL reset_mem got we=%b addr=%h wdata=%h exp 0", bus0.mem_we, bus0.mem_addr, bus0.mem_wdata); end
        checks++; if (bus0.if_rdata !== 32'd0 || bus0.dm_rdata !== 32'd0 || bus0.if_fault !== 1'b0 || bus0.dm_fault !== 1'b0) begin errors++; $display("FAIL reset_rdata got if=%h dm=%h exp 0", bus0.if_rdata, bus0.dm_rdata); end
    endtask

    task automatic test_fetch();
        logic [31:0] rd; logic flt; int lat;
        preload(10'h010, 32'h1234_5678);
        op0(1'b0, 1'b0, 32'h10, 32'd0, rd, flt, lat);
        checks++; if (rd !== 32'h1234_5678) begin errors++; $display("FAIL fetch_rdata got=%h exp=12345678", rd); end
        checks++; if (flt !== 1'b0) begin errors++; $display("FAIL fetch_fault got=%b exp=0", flt); end
        checks++; if (lat !== 2) begin errors++; $display("FAIL fetch_latency got=%0d exp=2", lat); end
    endtask

    task automatic test_store_load();
        logic [31:0] rd; logic flt; int lat;
        op0(1'b1, 1'b1, 32'h20, 32'hDEAD_BEEF, rd, flt, lat);
        ref0[8] = 32'hDEAD_BEEF;
        checks++; if (rd !== 32'd0 || flt !== 1'b0 || lat !== 2) begin errors++; $display("FAIL store_resp got rd=%h flt=%b lat=%0d exp 0/0/2", rd, flt, lat); end
        checks++; if ({mem0[32], mem0[33], mem0[34], mem0[35]} !== 32'hDEAD_BEEF) begin errors++; $display("FAIL store_bytes got=%h%h%h%h exp=DEADBEEF", mem0[32], mem0[33], mem0[34], mem0[35]); end
        op0(1'b1, 1'b0, 32'h20, 32'd0, rd, flt, lat);
        checks++; if (rd !== 32'hDEAD_BEEF || flt !== 1'b0 || lat !== 2) begin errors++; $display("FAIL load_back got rd=%h flt=%b lat=%0d exp DEADBEEF/0/2", rd, flt, lat); end
    endtask

    task automatic test_fault();
        logic [31:0] rd; logic flt; int lat; int p0;
        logic [31:0] addrs [0:5];
        bit          dms [0:5];
        bit          wes [0:5];
        addrs = '{32'h22, 32'h3FD, 32'h400, 32'hFFFF_FFFC, 32'h3FE, 32'h401};
        dms   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        wes   = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        p0 = we_pulses0;
        for (int i = 0; i < 6; i++) begin
            op0(dms[i], wes[i], addrs[i], 32'hA5A5_A5A5, rd, flt, lat);
            checks++; if (flt !== 1'b1 || rd !== 32'd0 || lat !== 1) begin errors++; $display("FAIL fault_%0d addr=%h got flt=%b rd=%h lat=%0d exp 1/0/1", i, addrs[i], flt, rd, lat); end
        end
        checks++; if (we_pulses0 !== p0) begin errors++; $display("FAIL fault_mem_we got=%0d writes exp=0", we_pulses0 - p0); end
        op0(1'b1, 1'b0, 32'h3FC, 32'd0, rd, flt, lat);
        checks++; if (flt !== 1'b0 || rd !== ref0[255] || lat !== 2) begin errors++; $display("FAIL top_word got flt=%b rd=%h lat=%0d exp 0/%h/2", flt, rd, lat, ref0[255]); end
    endtask

    task automatic test_round_robin();
        int n; int times [0:7]; bit order [0:7];
        n = 0;
        @(posedge clk); #1;
        rst0 = 1'b1;
        bus0.if_req = 1'b1; bus0.if_addr = 32'h10;
        bus0.dm_req = 1'b1; bus0.dm_we = 1'b0; bus0.dm_addr = 32'h20;
        @(posedge clk); #1;
        rst0 = 1'b0;
        for (int k = 1; k <= 60 && n < 8; k++) begin
            @(posedge clk); #1;
            if (bus0.if_ready || bus0.dm_ready) begin
                checks++; if (bus0.if_ready && bus0.dm_ready) begin errors++; $display("FAIL rr_both_ready at cycle %0d", k); end
                checks++; if (bus0.if_ready && bus0.if_rdata !== ref0[4]) begin errors++; $display("FAIL rr_if_rdata got=%h exp=%h", bus0.if_rdata, ref0[4]); end
                checks++; if (bus0.dm_ready && bus0.dm_rdata !== ref0[8]) begin errors++; $display("FAIL rr_dm_rdata got=%h exp=%h", bus0.dm_rdata, ref0[8]); end
                order[n] = bus0.dm_ready;
                times[n] = k;
                n++;
            end
        end
        bus0.if_req = 1'b0; bus0.dm_req = 1'b0;
        checks++; if (n !== 8) begin errors++; $display("FAIL rr_count got=%0d exp=8", n); end
        for (int i = 0; i < n; i++) begin
            checks++; if (order[i] !== 1'(i % 2)) begin errors++; $display("FAIL rr_order[%0d] got=%0d exp=%0d (0=IF 1=DM)", i, order[i], i % 2); end
            if (i > 0) begin
                checks++; if (times[i] - times[i-1] !== 3) begin errors++; $display("FAIL rr_spacing[%0d] got=%0d exp=3", i, times[i] - times[i-1]); end
            end
        end
    endtask

    task automatic test_wait_states();
        int lat; int busy_cnt; logic [31:0] rd;
        lat = 0; busy_cnt = 0; rd = 32'd0;
        @(posedge clk); #1;
        bus1.if_req = 1'b1; bus1.if_addr = 32'h0;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk); #1;
            if (busy1) busy_cnt++;
            if (bus1.if_ready && lat == 0) begin
                lat = k; rd = bus1.if_rdata; bus1.if_req = 1'b0;
            end
        end
        bus1.if_req = 1'b0;
        checks++; if (lat !== 5) begin errors++; $display("FAIL ws_latency got=%0d exp=5", lat); end
        checks++; if (busy_cnt !== 5) begin errors++; $display("FAIL ws_busy_cycles got=%0d exp=5", busy_cnt); end
        checks++; if (rd !== ref1[0]) begin errors++; $display("FAIL ws_rdata got=%h exp=%h", rd, ref1[0]); end
    endtask

    task automatic test_reset_mid();
        int rdy; int lat; logic [31:0] rd;
        // Load interrupted by reset in the middle of its wait states.
        @(posedge clk); #1;
        bus1.dm_req = 1'b1; bus1.dm_we = 1'b0; bus1.dm_addr = 32'h40;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (busy1 !== 1'b1) begin errors++; $display("FAIL rm_busy_before got=%b exp=1", busy1); end
        rst1 = 1'b1; bus1.dm_req = 1'b0;
        @(posedge clk); #1;
        rst1 = 1'b0;
        checks++; if (busy1 !== 1'b0 || bus1.dm_ready !== 1'b0) begin errors++; $display("FAIL rm_after_reset got busy=%b ready=%b exp 0/0", busy1, bus1.dm_ready); end
        rdy = 0;
        repeat (6) begin @(posedge clk); #1; if (bus1.dm_ready) rdy++; end
        checks++; if (rdy !== 0) begin errors++; $display("FAIL rm_dropped got=%0d ready pulses exp=0", rdy); end
        // Reissued load completes normally.
        bus1.dm_req = 1'b1;
        lat = 0; rd = 32'd0;
        for (int k = 1; k <= 12 && lat == 0; k++) begin
            @(posedge clk); #1;
            if (bus1.dm_ready) begin lat = k; rd = bus1.dm_rdata; end
        end
        bus1.dm_req = 1'b0;
        checks++; if (lat !== 5 || rd !== ref1[16]) begin errors++; $display("FAIL rm_reissue got lat=%0d rd=%h exp 5/%h", lat, rd, ref1[16]); end
        // Reset in the final ACCESS cycle of a store: the write still lands.
        @(posedge clk); #1;
        bus1.dm_req = 1'b1; bus1.dm_we = 1'b1; bus1.dm_addr = 32'h44; bus1.dm_wdata = 32'hCAFE_F00D;
        repeat (4) @(posedge clk);
        #1;
        checks++; if (bus1.mem_we !== 1'b1) begin errors++; $display("FAIL rm_store_we got=%b exp=1", bus1.mem_we); end
        rst1 = 1'b1; bus1.dm_req = 1'b0; bus1.dm_we = 1'b0;
        @(posedge clk); #1;
        rst1 = 1'b0;
        ref1[17] = 32'hCAFE_F00D;
        checks++; if (bus1.dm_ready !== 1'b0 || busy1 !== 1'b0) begin errors++; $display("FAIL rm_store_resp got ready=%b busy=%b exp 0/0", bus1.dm_ready, busy1); end
        checks++; if ({mem1[68], mem1[69], mem1[70], mem1[71]} !== 32'hCAFE_F00D) begin errors++; $display("FAIL rm_store_bytes got=%h%h%h%h exp=CAFEF00D", mem1[68], mem1[69], mem1[70], mem1[71]); end
    endtask

    task automatic test_random();
        logic [31:0] ia, da, dwd, exp_i, exp_d;
        bit ui, ud, dwe, fi, fd, dm_first, last_dm;
        int t_if, t_dm, t_end;
        @(posedge clk); #1;
        rst0 = 1'b1;
        @(posedge clk); #1;
        rst0 = 1'b0;
        last_dm = 1'b1;
        for (int it = 0; it < 60; it++) begin
            ui = 1'($urandom_range(0, 1));
            ud = 1'($urandom_range(0, 1));
            if (!ui && !ud) ui = 1'b1;
            ia = rand_addr(); da = rand_addr();
            dwe = 1'($urandom_range(0, 1)); dwd = $urandom();
            fi = addr_bad(ia); fd = addr_bad(da);
            dm_first = ud && (!ui || !last_dm);
            exp_i = 32'd0; exp_d = 32'd0; t_if = 0; t_dm = 0;
            // Serve the ports in grant order; the second starts two edges after the first completes.
            for (int s = 0; s < 2; s++) begin
                bit is_dm; int done_t;
                is_dm = (s == 0) ? dm_first : !dm_first;
                if ((is_dm && ud) || (!is_dm && ui)) begin
                    done_t = ((s == 0) ? 0 : t_if + t_dm + 1) + ((is_dm ? fd : fi) ? 1 : 2);
                    if (is_dm) begin
                        t_dm = done_t;
                        if (!fd) begin
                            if (dwe) ref0[da[9:2]] = dwd;
                            else exp_d = ref0[da[9:2]];
                        end
                    end else begin
                        t_if = done_t;
                        if (!fi) exp_i = ref0[ia[9:2]];
                    end
                end
            end
            last_dm = (ui && ud) ? !dm_first : ud;
            t_end = ((t_if > t_dm) ? t_if : t_dm) + 1;
            @(posedge clk); #1;
            bus0.if_req = ui; bus0.if_addr = ia;
            bus0.dm_req = ud; bus0.dm_we = dwe; bus0.dm_addr = da; bus0.dm_wdata = dwd;
            for (int t = 1; t <= t_end; t++) begin
                @(posedge clk); #1;
                checks++; if (bus0.if_ready !== (ui && t == t_if)) begin errors++; $display("FAIL rnd%0d_if_ready t=%0d got=%b exp=%b", it, t, bus0.if_ready, (ui && t == t_if)); end
                checks++; if (bus0.dm_ready !== (ud && t == t_dm)) begin errors++; $display("FAIL rnd%0d_dm_ready t=%0d got=%b exp=%b", it, t, bus0.dm_ready, (ud && t == t_dm)); end
                if (ui && t == t_if) begin
                    checks++; if (bus0.if_rdata !== exp_i || bus0.if_fault !== fi) begin errors++; $display("FAIL rnd%0d_if addr=%h got rd=%h flt=%b exp %h/%b", it, ia, bus0.if_rdata, bus0.if_fault, exp_i, fi); end
                    bus0.if_req = 1'b0;
                end
                if (ud && t == t_dm) begin
                    checks++; if (bus0.dm_rdata !== exp_d || bus0.dm_fault !== fd) begin errors++; $display("FAIL rnd%0d_dm addr=%h we=%b got rd=%h flt=%b exp %h/%b", it, da, dwe, bus0.dm_rdata, bus0.dm_fault, exp_d, fd); end
                    bus0.dm_req = 1'b0;
                end
            end
            bus0.if_req = 1'b0; bus0.dm_req = 1'b0;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst0 = 1'b1; rst1 = 1'b1;
        bus0.if_req = 1'b0; bus0.if_addr = 32'd0; bus0.dm_req = 1'b0; bus0.dm_we = 1'b0;
        bus0.dm_addr = 32'd0; bus0.dm_wdata = 32'd0;
        bus1.if_req = 1'b0; bus1.if_addr = 32'd0; bus1.dm_req = 1'b0; bus1.dm_we = 1'b0;
        bus1.dm_addr = 32'd0; bus1.dm_wdata = 32'd0;
        for (int w = 0; w < 256; w++) preload(10'(w * 4), $urandom());
        @(posedge clk); #1;
        test_reset();
        rst0 = 1'b0; rst1 = 1'b0;
        test_fetch();
        test_store_load();
        test_fault();
        test_round_robin();
        test_wait_states();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
